// File: rtl/fetch_icache_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and its I-cache.
package fetch_icache_unit_pkg;

    // Next-PC source selected by the hazard unit / MEM-stage redirect logic.
    typedef enum logic [1:0] {
        NEXT_PC     = 2'd0,
        BRANCH_ALU  = 2'd1,
        BRANCH_JUMP = 2'd2
    } pc_sel_e;

    // Fetch controller states.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REFILL = 2'd1,
        LOAD   = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0 -- issued whenever no real instruction is available.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_icache_unit_icache_dm.sv
// Direct-mapped I-cache storage (the icache_dm block): tag, valid and data arrays,
// a combinational lookup port, a single-word data write port used during refill,
// a line-fill port that sets tag and valid, and a whole-cache valid flush.
module fetch_icache_unit_icache_dm
    import fetch_icache_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 12,
    parameter int IDX_W = 4,
    parameter int OFF_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [XLEN-1:0]  rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [TAG_W-1:0] fill_tag
);

    localparam int NUM_LINES = 1 << IDX_W;
    localparam int NUM_WORDS = NUM_LINES << OFF_W;

    logic [XLEN-1:0]      data_mem [NUM_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_reg;

    // Data words are written one at a time as the SRAM returns them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
    end

    // Tag is written together with the last word of the line.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

    // Valid bits: cleared by reset or flush, set when a line fill completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else if (fill_en) begin
            valid_reg[fill_index] <= 1'b1;
        end
    end

    assign hit     = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/fetch_icache_unit.sv
// Instruction-fetch stage: PC register, next-PC select, direct-mapped I-cache with
// multi-word line refill from a 1-cycle-latency SRAM, and a program-load port.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module fetch_icache_unit
    import fetch_icache_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ADDR_W     = 20,
    parameter int              LINE_WORDS = 4,
    parameter int              NUM_LINES  = 16,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              stall_i,
    input  logic [1:0]        pc_sel_i,
    input  logic [XLEN-1:0]   alu_target_i,
    input  logic [XLEN-1:0]   jump_target_i,
    input  logic              tb_load_i,
    input  logic [ADDR_W-1:0] tb_addr_i,
    input  logic [XLEN-1:0]   tb_data_i,
    output logic              imem_csb_o,
    output logic              imem_web_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [XLEN-1:0]   imem_din_o,
    input  logic [XLEN-1:0]   imem_dout_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   pc_link_o,
    output logic [XLEN-1:0]   instr_o,
    output logic              instr_valid_o
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_LO = 2 + OFF_W + IDX_W;
    localparam int TAG_W  = ADDR_W - TAG_LO;

    localparam logic [OFF_W:0]   LAST_CNT  = (OFF_W + 1)'(LINE_WORDS);
    localparam logic [OFF_W:0]   CNT_ONE   = (OFF_W + 1)'(1);
    localparam logic [OFF_W-1:0] OFF_ONE   = OFF_W'(1);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]  ALIGN_LOW = XLEN'(3);

    fetch_state_e     state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [OFF_W:0]   cnt_reg, cnt_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [XLEN-1:0]  pend_pc_reg, pend_pc_next;

    logic             hit;
    logic [XLEN-1:0]  rd_data;
    logic             wr_en, fill_en, flush;
    logic [OFF_W-1:0] cap_offset;
    logic [XLEN-1:0]  target_raw, sel_pc;
    logic             redirect;
    logic             run_hit;

    // Address split of the current PC.
    logic [OFF_W-1:0] pc_offset;
    logic [IDX_W-1:0] pc_index;
    logic [TAG_W-1:0] pc_tag;

    assign pc_offset  = pc_reg[2 +: OFF_W];
    assign pc_index   = pc_reg[2 + OFF_W +: IDX_W];
    assign pc_tag     = pc_reg[ADDR_W-1:TAG_LO];
    assign cap_offset = cnt_reg[OFF_W-1:0] - OFF_ONE;

    fetch_icache_unit_icache_dm #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W),
        .OFF_W (OFF_W)
    ) u_icache (
        .clk        (CLK),
        .rst_n      (RSTn),
        .flush      (flush),
        .rd_index   (pc_index),
        .rd_offset  (pc_offset),
        .rd_tag     (pc_tag),
        .hit        (hit),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_index   (pc_index),
        .wr_offset  (cap_offset),
        .wr_data    (imem_dout_i),
        .fill_en    (fill_en),
        .fill_index (pc_index),
        .fill_tag   (pc_tag)
    );

    // Next-PC select; targets are word-aligned by clearing the low two bits.
    always_comb begin
        target_raw = pc_reg + PC_STEP;
        redirect   = 1'b0;
        case (pc_sel_e'(pc_sel_i))
            BRANCH_ALU: begin
                target_raw = alu_target_i;
                redirect   = 1'b1;
            end
            BRANCH_JUMP: begin
                target_raw = jump_target_i;
                redirect   = 1'b1;
            end
            default: target_raw = pc_reg + PC_STEP;
        endcase
        sel_pc = target_raw & ~ALIGN_LOW;
    end

    // Fetch controller: state transitions, SRAM port and cache write control.
    // A redirect that arrives while the line is missing is parked in the pending
    // register so it is not lost; a redirect during a stalled hit is held off by
    // the hazard unit, which never stalls a redirecting instruction.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        cnt_next        = cnt_reg;
        pend_valid_next = pend_valid_reg;
        pend_pc_next    = pend_pc_reg;
        imem_csb_o      = 1'b1;
        imem_web_o      = 1'b1;
        imem_addr_o     = '0;
        imem_din_o      = '0;
        wr_en           = 1'b0;
        fill_en         = 1'b0;
        flush           = 1'b0;
        if (EN) begin
            if (tb_load_i) begin
                state_next      = LOAD;
                cnt_next        = '0;
                pend_valid_next = 1'b0;
                flush           = 1'b1;
                imem_csb_o      = 1'b0;
                imem_web_o      = 1'b0;
                imem_addr_o     = tb_addr_i;
                imem_din_o      = tb_data_i;
            end else begin
                case (state_reg)
                    RUN: begin
                        if (hit) begin
                            if (!stall_i) begin
                                pc_next = sel_pc;
                            end
                        end else begin
                            state_next = REFILL;
                            cnt_next   = '0;
                            if (redirect) begin
                                pend_valid_next = 1'b1;
                                pend_pc_next    = sel_pc;
                            end
                        end
                    end
                    REFILL: begin
                        if (redirect) begin
                            pend_valid_next = 1'b1;
                            pend_pc_next    = sel_pc;
                        end
                        if (cnt_reg != LAST_CNT) begin
                            imem_csb_o  = 1'b0;
                            imem_addr_o = {pc_reg[ADDR_W-1:2+OFF_W], cnt_reg[OFF_W-1:0], 2'b00};
                        end
                        if (cnt_reg != '0) begin
                            wr_en = 1'b1;
                        end
                        if (cnt_reg == LAST_CNT) begin
                            fill_en         = 1'b1;
                            state_next      = RUN;
                            cnt_next        = '0;
                            pend_valid_next = 1'b0;
                            if (redirect) begin
                                pc_next = sel_pc;
                            end else if (pend_valid_reg) begin
                                pc_next = pend_pc_reg;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                    LOAD: begin
                        state_next      = RUN;
                        pc_next         = RESET_PC;
                        pend_valid_next = 1'b0;
                    end
                    default: state_next = RUN;
                endcase
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            cnt_reg        <= '0;
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            cnt_reg        <= cnt_next;
            pend_valid_reg <= pend_valid_next;
            pend_pc_reg    <= pend_pc_next;
        end
    end

    assign run_hit       = (state_reg == RUN) && hit && !tb_load_i;
    assign instr_valid_o = run_hit;
    assign instr_o       = run_hit ? rd_data : XLEN'(NOP_INSTR);
    assign pc_o          = pc_reg;
    assign pc_link_o     = pc_reg + PC_STEP;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_reg, miss_cnt_reg;

    // Saturating hit/miss statistics, restarted by reset and program load.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (tb_load_i) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (EN && (state_reg == RUN)) begin
            if (hit && !stall_i && (hit_cnt_reg != '1)) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (!hit && (miss_cnt_reg != '1)) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_icache_unit.sv
// Directed testbench for fetch_icache_unit with a 1-cycle-latency SRAM model.
module tb_fetch_icache_unit;
    import fetch_icache_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] alu_target;
    logic [31:0] jump_target;
    logic        tb_load;
    logic [19:0] tb_addr;
    logic [31:0] tb_data;
    logic        imem_csb;
    logic        imem_web;
    logic [19:0] imem_addr;
    logic [31:0] imem_din;
    logic [31:0] imem_dout;
    logic [31:0] pc;
    logic [31:0] pc_link;
    logic [31:0] instr;
    logic        instr_valid;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [1024];

    fetch_icache_unit dut (
        .CLK           (clk),
        .RSTn          (rst_n),
        .EN            (en),
        .stall_i       (stall),
        .pc_sel_i      (pc_sel),
        .alu_target_i  (alu_target),
        .jump_target_i (jump_target),
        .tb_load_i     (tb_load),
        .tb_addr_i     (tb_addr),
        .tb_data_i     (tb_data),
        .imem_csb_o    (imem_csb),
        .imem_web_o    (imem_web),
        .imem_addr_o   (imem_addr),
        .imem_din_o    (imem_din),
        .imem_dout_i   (imem_dout),
        .pc_o          (pc),
        .pc_link_o     (pc_link),
        .instr_o       (instr),
        .instr_valid_o (instr_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write-through on web=0, registered read data on web=1.
    always @(posedge clk) begin
        if (!imem_csb) begin
            if (!imem_web) begin
                mem[imem_addr[11:2]] <= imem_din;
            end else begin
                imem_dout <= mem[imem_addr[11:2]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetched-instruction check: pc, instruction word and valid flag.
    task automatic chk_fetch(input string tag, input logic [31:0] exp_pc,
                             input logic [31:0] exp_instr, input logic exp_valid);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".instr"}, instr, exp_instr);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, exp_valid});
        $display("fetch %s pc=%h instr=%h valid=%0d", tag, pc, instr, instr_valid);
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        stall       = 1'b0;
        pc_sel      = NEXT_PC;
        alu_target  = '0;
        jump_target = '0;
        tb_load     = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;
        tick();
        tick();

        // Reset state.
        chk_fetch("reset", 32'h0, 32'h0000_0013, 1'b0);
        chk("reset.csb", {31'd0, imem_csb}, 32'd1);
        chk("reset.link", pc_link, 32'h4);

        // Program load: 8 words at 0x00, 8 words at 0x40.
        tb_load = 1'b1;
        tb_addr = 20'h0;
        tb_data = 32'hA000_0000;
        #1;
        chk("load.csb", {31'd0, imem_csb}, 32'd0);
        chk("load.web", {31'd0, imem_web}, 32'd0);
        chk("load.din", imem_din, 32'hA000_0000);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tb_addr = 20'(i * 4);
            tb_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            tb_addr = 20'h40 + 20'(i * 4);
            tb_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        chk("load.addr", {12'd0, imem_addr}, 32'h5C);
        tb_load = 1'b0;
        tick();

        // First fetch misses, then a 5-cycle refill of line 0.
        chk_fetch("miss0", 32'h0, 32'h0000_0013, 1'b0);
        chk("miss0.csb", {31'd0, imem_csb}, 32'd1);
        tick();
        chk("refill.k0.csb", {31'd0, imem_csb}, 32'd0);
        chk("refill.k0.addr", {12'd0, imem_addr}, 32'h0);
        tick();
        chk("refill.k1.addr", {12'd0, imem_addr}, 32'h4);
        tick();
        tick();
        chk("refill.k3.addr", {12'd0, imem_addr}, 32'hC);
        tick();
        chk("refill.last.csb", {31'd0, imem_csb}, 32'd1);
        chk("refill.last.valid", {31'd0, instr_valid}, 32'd0);
        tick();

        // Words 0..3 on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            chk_fetch($sformatf("p1w%0d", i), 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
            tick();
        end

        // Line boundary at 0x10: second miss, refill, words 4..7.
        chk_fetch("miss1", 32'h10, 32'h0000_0013, 1'b0);
        repeat (6) tick();
        for (int i = 4; i < 8; i++) begin
            chk_fetch($sformatf("p1w%0d", i), 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
            if (i == 7) begin
                pc_sel      = BRANCH_JUMP;
                jump_target = 32'h0;
            end
            tick();
        end
        pc_sel = NEXT_PC;

        // Second pass: 8 consecutive hits, no refill.
        for (int i = 0; i < 8; i++) begin
            chk_fetch($sformatf("p2w%0d", i), 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
            if (i == 7) begin
`ifdef ICACHE_STATS_EN
                chk("stats.miss", miss_cnt, 32'd2);
                chk("stats.hit", hit_cnt, 32'd15);
`endif
                pc_sel     = BRANCH_ALU;
                alu_target = 32'h6;
            end
            tick();
        end
        pc_sel = NEXT_PC;

        // ALU redirect with misaligned target lands on 0x4; then stall 3 cycles.
        chk_fetch("alu", 32'h4, 32'hA000_0001, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_fetch($sformatf("stall%0d", i), 32'h4, 32'hA000_0001, 1'b1);
        end
        stall = 1'b0;
        tick();
        chk_fetch("resume", 32'h8, 32'hA000_0002, 1'b1);
        chk("resume.link", pc_link, 32'hC);

        // EN=0 freezes the PC.
        en = 1'b0;
        tick();
        tick();
        chk_fetch("en_off", 32'h8, 32'hA000_0002, 1'b1);
        en = 1'b1;

        // Jump to 0x40 (miss), reset two cycles into the refill.
        pc_sel      = BRANCH_JUMP;
        jump_target = 32'h40;
        tick();
        pc_sel = NEXT_PC;
        chk_fetch("j40", 32'h40, 32'h0000_0013, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_fetch("rst_mid", 32'h0, 32'h0000_0013, 1'b0);
        chk("rst_mid.csb", {31'd0, imem_csb}, 32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        chk_fetch("rst_rerun", 32'h0, 32'h0000_0013, 1'b0);

        // Refill line 0 with a jump to 0x40 on refill cycle 2.
        tick();
        tick();
        tick();
        pc_sel      = BRANCH_JUMP;
        jump_target = 32'h40;
        tick();
        pc_sel      = NEXT_PC;
        jump_target = 32'h0;
        tick();
        tick();
        chk_fetch("pend", 32'h40, 32'h0000_0013, 1'b0);
        repeat (6) tick();
        chk_fetch("hit40", 32'h40, 32'hB000_0000, 1'b1);

        // Line 0 was completed despite the redirect: jumping back hits at once.
        pc_sel      = BRANCH_JUMP;
        jump_target = 32'h0;
        tick();
        pc_sel = NEXT_PC;
        chk_fetch("back0", 32'h0, 32'hA000_0000, 1'b1);
        tick();
        chk_fetch("back4", 32'h4, 32'hA000_0001, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
